// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
// Holds the forward-select encodings, the MDU tracker state type and a small select helper.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_ME   = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // Wide enough for the largest legal MDU latency (15).
  localparam int MDU_CNT_W = 4;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_t;

  // The newer producer (ME) wins over the older one (WB).
  function automatic logic [1:0] fwd_sel(input logic me_hit, input logic wb_hit);
    logic [1:0] sel;
    if (me_hit) begin
      sel = FWD_ME;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mdu_tracker.sv
// Tracks an in-flight multi-cycle MDU operation: IDLE -> BUSY (MDU_LAT-1 cycles) -> DONE.
// start_i must already be qualified (not stalled, not flushed, not in reset).
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic busy_o
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);
  localparam logic [MDU_CNT_W-1:0] CNT_ZERO = MDU_CNT_W'(0);

  mdu_state_t           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and busy decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = MDU_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      MDU_BUSY: begin
        busy_o = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_d = MDU_DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = MDU_BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      MDU_DONE: begin
        // A back-to-back op skips IDLE so the result slot is reused immediately.
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = MDU_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, data/MDU stalls, branch/jump flushes.
// Define HAZARD_FWD_EN for forwarding with load-use stalls; otherwise EX/ME producers stall decode.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic [REG_W-1:0] Rs_EX,
  input  logic [REG_W-1:0] Rt_EX,
  input  logic [REG_W-1:0] WriteReg_EX,
  input  logic [REG_W-1:0] WriteReg_ME,
  input  logic [REG_W-1:0] WriteReg_WB,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_ME,
  input  logic             RegWrite_WB,
  input  logic             MemToReg_EX,
  input  logic             BranchTaken_EX,
  input  logic             Jump_ID,
  input  logic             MduStart_ID,
  input  logic             MduRead_ID,
  output logic             Stall_IF,
  output logic             Stall_ID,
  output logic             Flush_ID,
  output logic             Flush_EX,
  output logic [1:0]       FwdA_EX,
  output logic [1:0]       FwdB_EX,
  output logic             AnyStall,
  output logic             MduBusy
);

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic hit(input logic we, input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] src);
    return we && (dst != {REG_W{1'b0}}) && (dst == src);
  endfunction

  logic       data_stall_s;
  logic       mdu_stall_s;
  logic       stall_s;
  logic       mdu_busy_s;
  logic       mdu_start_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load feeding decode must wait.
  always_comb begin
    data_stall_s = MemToReg_EX && (hit(RegWrite_EX, WriteReg_EX, Rs_ID) ||
                                   hit(RegWrite_EX, WriteReg_EX, Rt_ID));
    fwd_a_s = fwd_sel(hit(RegWrite_ME, WriteReg_ME, Rs_EX), hit(RegWrite_WB, WriteReg_WB, Rs_EX));
    fwd_b_s = fwd_sel(hit(RegWrite_ME, WriteReg_ME, Rt_EX), hit(RegWrite_WB, WriteReg_WB, Rt_EX));
  end
`else
  logic unused_s;
  assign unused_s = ^{Rs_EX, Rt_EX, WriteReg_WB, RegWrite_WB, MemToReg_EX};

  // Without forwarding, decode waits until the producer has left EX and ME.
  always_comb begin
    data_stall_s = hit(RegWrite_EX, WriteReg_EX, Rs_ID) || hit(RegWrite_EX, WriteReg_EX, Rt_ID) ||
                   hit(RegWrite_ME, WriteReg_ME, Rs_ID) || hit(RegWrite_ME, WriteReg_ME, Rt_ID);
    fwd_a_s = FWD_NONE;
    fwd_b_s = FWD_NONE;
  end
`endif

  // Stall/flush priority: reset, then branch, then stall, then jump.
  always_comb begin
    mdu_stall_s = mdu_busy_s && (MduStart_ID || MduRead_ID);
    stall_s     = data_stall_s || mdu_stall_s;
    Stall_IF    = 1'b0;
    Stall_ID    = 1'b0;
    Flush_ID    = 1'b0;
    Flush_EX    = 1'b0;
    if (!reset) begin
      Flush_ID = 1'b0;
    end else if (BranchTaken_EX) begin
      Flush_ID = 1'b1;
      Flush_EX = 1'b1;
    end else if (stall_s) begin
      // A jump held here simply re-presents itself once the stall clears.
      Stall_IF = 1'b1;
      Stall_ID = 1'b1;
      Flush_EX = 1'b1;
    end else if (Jump_ID) begin
      Flush_ID = 1'b1;
    end else begin
      Flush_ID = 1'b0;
    end
    AnyStall    = Stall_IF || Stall_ID;
    FwdA_EX     = reset ? fwd_a_s : FWD_NONE;
    FwdB_EX     = reset ? fwd_b_s : FWD_NONE;
    MduBusy     = reset && mdu_busy_s;
    mdu_start_s = reset && MduStart_ID && !stall_s && !BranchTaken_EX;
  end

  mdu_tracker #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_tracker (
    .clk    (clk),
    .reset  (reset),
    .start_i(mdu_start_s),
    .busy_o (mdu_busy_s)
  );

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter MDU_LAT, default 4, multi-cycle MDU latency in cycles (legal range 2..15).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports Rs_ID and Rt_ID, input, REG_W each, source registers in decode.
REQ-006 SHALL have ports Rs_EX and Rt_EX, input, REG_W each, source registers in execute.
REQ-007 SHALL have ports WriteReg_EX, WriteReg_ME and WriteReg_WB, input, REG_W each, destination registers.
REQ-008 SHALL have ports RegWrite_EX, RegWrite_ME, RegWrite_WB and MemToReg_EX, input, 1 each, write and load flags.
REQ-009 SHALL have ports BranchTaken_EX and Jump_ID, input, 1 each, redirect events.
REQ-010 SHALL have ports MduStart_ID and MduRead_ID, input, 1 each: decode starts an MDU op, or decode reads the MDU result.
REQ-011 SHALL have ports Stall_IF, Stall_ID, Flush_ID and Flush_EX, output, 1 each.
REQ-012 SHALL have ports FwdA_EX and FwdB_EX, output, 2 each, ALU operand forward selects.
REQ-013 SHALL have ports AnyStall, output, 1, OR of the stalls, and MduBusy, output, 1.

Function
REQ-014 Register 0 SHALL never match, so it never causes a forward or a stall.
REQ-015 FwdX_EX SHALL be: 2'b01 when RegWrite_ME and WriteReg_ME equals Rs_EX/Rt_EX; otherwise 2'b10 when RegWrite_WB and WriteReg_WB matches; otherwise 2'b00. ME has priority over WB.
REQ-016 Load-use: when MemToReg_EX, RegWrite_EX and WriteReg_EX equals Rs_ID or Rt_ID, the unit SHALL assert Stall_IF, Stall_ID and Flush_EX for exactly 1 cycle.
REQ-017 MDU FSM states SHALL be IDLE, BUSY and DONE.
REQ-018 IDLE SHALL go to BUSY on an unstalled MduStart_ID, loading a counter with MDU_LAT-1.
REQ-019 BUSY SHALL decrement the counter and go to DONE when the counter reaches 1.
REQ-020 DONE SHALL go to IDLE after 1 cycle, or directly back to BUSY on a new unstalled MduStart_ID.
REQ-021 MduBusy SHALL be 1 in BUSY.
REQ-022 While in BUSY, MduStart_ID or MduRead_ID SHALL assert Stall_IF and Stall_ID, and Flush_EX SHALL insert a bubble.
REQ-023 BranchTaken_EX SHALL assert Flush_ID and Flush_EX in the same cycle.
REQ-024 A branch flush SHALL override every stall in that cycle: Stall_IF=Stall_ID=0.
REQ-025 A flushed MduStart_ID SHALL NOT start the FSM.
REQ-026 Jump_ID with no stall SHALL assert Flush_ID only.
REQ-027 Jump_ID during a stall SHALL be held, with no flush, until the stall clears.
REQ-028 AnyStall SHALL equal Stall_IF | Stall_ID.
REQ-029 Stall, flush and forward outputs SHALL be combinational from inputs and FSM state, with 0-cycle latency.

Reset
REQ-030 On reset low at a clk edge, the FSM SHALL go to IDLE and the counter SHALL be 0.
REQ-031 While reset is low, all outputs SHALL be 0.
REQ-032 Reset SHALL abort an in-flight MDU op without asserting DONE.

Configuration
REQ-033 Macro HAZARD_FWD_EN SHALL control forwarding.
REQ-034 With HAZARD_FWD_EN defined, REQ-015 and REQ-016 SHALL apply.
REQ-035 With HAZARD_FWD_EN undefined, FwdA_EX and FwdB_EX SHALL be tied to 2'b00.
REQ-036 With HAZARD_FWD_EN undefined, the unit SHALL stall IF/ID and flush EX whenever Rs_ID/Rt_ID matches an active write in EX or ME, until no match remains.

Structure
REQ-037 Shared package hazard_pkg SHALL hold the forward encodings FWD_NONE, FWD_ME and FWD_WB, and the MDU state typedef mdu_state_t.
REQ-038 The MDU FSM and counter SHALL be one sub-module, mdu_tracker; all compare logic SHALL stay in hazard_unit.

Verification
REQ-039 With WriteReg_ME=5, RegWrite_ME=1, WriteReg_WB=5, RegWrite_WB=1 and Rs_EX=5 -> FwdA_EX=2'b01; with RegWrite_ME=0 -> FwdA_EX=2'b10; with Rs_EX=0 -> FwdA_EX=2'b00.
REQ-040 With MemToReg_EX=1, WriteReg_EX=8 and Rt_ID=8 -> Stall_IF, Stall_ID and Flush_EX are 1 for 1 cycle, then 0.
REQ-041 With MDU_LAT=4, MduStart_ID at cycle 0 and MduRead_ID held high -> stalls in cycles 1-3, released in DONE at cycle 4.
REQ-042 With BranchTaken_EX=1 during a load-use stall -> Flush_ID=Flush_EX=1 and Stall_IF=0.
REQ-043 With reset low at cycle 2 of BUSY -> next cycle is IDLE and MduBusy=0.
REQ-044 With HAZARD_FWD_EN undefined, WriteReg_EX=3 and Rs_ID=3 -> stall 2 cycles (EX, then ME), FwdA_EX=2'b00.
